// File: rtl/tdc_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_conv_ctrl
//   Conversion sequencer for an N_BIT time-to-digital converter. A request is
//   accepted over a valid/ready handshake. Each round clears the TDC flops,
//   fires one start strobe to the DTC front end, waits SETTLE cycles for both
//   edges to cross the delay cascade, then captures the TDC code into an
//   accumulator. The result is held in HOLD until the consumer takes it.
//
//   Optional feature (macro TDC_CTRL_ACC_EN):
//     defined   - each request runs 2^ACC_LOG2 rounds; res_data is the sum.
//     undefined - one round per request; upper ACC_LOG2 bits of res_data are 0.
//
// Parameters:
//   N_BIT    TDC code width (must match the attached tdc instance)
//   SETTLE   cycles between start strobe and capture, 1..255
//   ACC_LOG2 log2 of rounds averaged per request, 0..4
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   req_valid   requester asks for a conversion
//   req_ready   controller can accept a request (IDLE only)
//   conv_start  one-cycle strobe launching the in/clk edge pair
//   tdc_rst_n   active-low clear for the tdc flops
//   tdc_out     raw TDC code
//   res_valid   result available
//   res_ready   consumer accepts result
//   res_data    zero-extended code, or sum of codes
//   busy        high in any state other than IDLE
// -----------------------------------------------------------------------------
module tdc_conv_ctrl #(
  parameter int N_BIT    = 2,
  parameter int SETTLE   = 4,
  parameter int ACC_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic                      conv_start,
  output logic                      tdc_rst_n,
  input  logic [N_BIT-1:0]          tdc_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [N_BIT+ACC_LOG2-1:0] res_data,
  output logic                      busy
);

  localparam int ACC_W = N_BIT + ACC_LOG2;
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FIRE, S_WAIT, S_CAPT, S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       settle_cnt;
  logic [ACC_W-1:0] acc;
  logic             accept;
  logic             more_rounds;

  // Next-cycle values of the registered outputs.
  logic req_ready_d, conv_start_d, tdc_rst_n_d, res_valid_d, busy_d;

  assign accept = (state_q == S_IDLE) && req_valid && req_ready;

`ifdef TDC_CTRL_ACC_EN
  localparam int REM_W = ACC_LOG2 + 1;
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'((1 << ACC_LOG2) - 1);

  // Rounds still to run after the current one.
  logic [REM_W-1:0] rem_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                  rem_cnt <= '0;
    else if (accept)                          rem_cnt <= REM_LOAD;
    else if (state_q == S_CAPT && more_rounds) rem_cnt <= rem_cnt - 1'b1;
  end

  assign more_rounds = (rem_cnt != '0);
`else
  assign more_rounds = 1'b0;
`endif

  // Next-state and output decode. Outputs are decoded from the next state and
  // then registered, so they change exactly on the edge the state changes and
  // read as all-zero while reset is held.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)                  state_d = S_CLR;
      S_CLR:                               state_d = S_FIRE;
      S_FIRE:                              state_d = S_WAIT;
      S_WAIT: if (settle_cnt == 8'd0)      state_d = S_CAPT;
      S_CAPT:                              state_d = more_rounds ? S_CLR : S_HOLD;
      S_HOLD: if (res_valid && res_ready)  state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    conv_start_d = (state_d == S_FIRE);
    tdc_rst_n_d  = (state_d != S_CLR);
    res_valid_d  = (state_d == S_HOLD);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_ready  <= 1'b0;
      conv_start <= 1'b0;
      tdc_rst_n  <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_ready  <= req_ready_d;
      conv_start <= conv_start_d;
      tdc_rst_n  <= tdc_rst_n_d;
      res_valid  <= res_valid_d;
      busy       <= busy_d;
    end
  end

  // Settle counter: loaded in FIRE so WAIT spans SETTLE-1 down to 0.
  always_ff @(posedge clk) begin
    if (rst)                                      settle_cnt <= '0;
    else if (state_q == S_FIRE)                   settle_cnt <= SETTLE_LOAD;
    else if (state_q == S_WAIT && settle_cnt != 0) settle_cnt <= settle_cnt - 8'd1;
  end

  // Accumulator: wide enough for 2^ACC_LOG2 full-scale codes, so no overflow.
  always_ff @(posedge clk) begin
    if (rst)                    acc <= '0;
    else if (accept)            acc <= '0;
    else if (state_q == S_CAPT) acc <= acc + ACC_W'(tdc_out);
  end

  // acc only moves in CAPT or on accept, so it is stable throughout HOLD.
  assign res_data = acc;

endmodule

// File: tb/tb_tdc_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_conv_ctrl
//   Directed bench for tdc_conv_ctrl (N_BIT=2, SETTLE=4, ACC_LOG2=2). A small
//   TDC model loads the next code from code_tab on each conv_start and clears
//   while tdc_rst_n is low. Expected values are hand-computed; timing values
//   scale with ROUNDS so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_tdc_conv_ctrl;

  localparam int N_BIT    = 2;
  localparam int SETTLE   = 4;
  localparam int ACC_LOG2 = 2;
  localparam int ACC_W    = N_BIT + ACC_LOG2;
`ifdef TDC_CTRL_ACC_EN
  localparam int ROUNDS = 1 << ACC_LOG2;
`else
  localparam int ROUNDS = 1;
`endif
  localparam int RND_LEN = SETTLE + 3;          // cycles per round
  localparam int LAT     = ROUNDS * RND_LEN;    // accept to res_valid
  localparam int PERIOD  = LAT + 2;             // back-to-back spacing

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             conv_start;
  logic             tdc_rst_n;
  logic [N_BIT-1:0] tdc_out;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  tdc_conv_ctrl #(.N_BIT(N_BIT), .SETTLE(SETTLE), .ACC_LOG2(ACC_LOG2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .conv_start (conv_start),
    .tdc_rst_n  (tdc_rst_n),
    .tdc_out    (tdc_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // TDC model: next code from the table on each strobe, cleared by tdc_rst_n.
  logic [N_BIT-1:0] code_tab [4];
  int start_cnt = 0;
  int base      = 0;

  always @(posedge clk) begin
    if (conv_start) begin
      tdc_out   <= code_tab[2'(start_cnt - base)];
      start_cnt <= start_cnt + 1;
    end else if (!tdc_rst_n) begin
      tdc_out <= '0;
    end
  end

  // Results of the last run_one call.
  int r_lat, r_nstarts, r_nclr, r_firstclr;
  int r_start [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and follow it until res_valid (bounded).
  // t=0 is the cycle right after the accept edge.
  task automatic run_one(input logic [1:0] c0, c1, c2, c3);
    code_tab[0] = c0; code_tab[1] = c1; code_tab[2] = c2; code_tab[3] = c3;
    base       = start_cnt;
    r_lat      = -1;
    r_nstarts  = 0;
    r_nclr     = 0;
    r_firstclr = -1;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (res_valid) begin r_lat = t; break; end
      if (!tdc_rst_n) begin
        if (r_firstclr < 0) r_firstclr = t;
        r_nclr++;
      end
      if (conv_start) begin
        if (r_nstarts < 8) r_start[r_nstarts] = t;
        r_nstarts++;
      end
      tick();
    end
    tests_run++;
    if (r_lat < 0) begin
      tests_failed++;
      $display("FAIL run_one_timeout: res_valid never rose within 200 cycles");
    end
  endtask

  task automatic finish_hold();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      tests_run++; if (tdc_rst_n !== 1'b0) begin tests_failed++; $display("FAIL rst_tdc_rst_n: got %b want 0", tdc_rst_n); end
      tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
      tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    end
    tests_run++; if (res_data !== '0) begin tests_failed++; $display("FAIL rst_res_data: got %0d want 0", res_data); end
    rst = 1'b0;
    tick();
    tests_run++; if (req_ready !== 1'b1)  begin tests_failed++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    tests_run++; if (tdc_rst_n !== 1'b1)  begin tests_failed++; $display("FAIL idle_tdc_rst_n: got %b want 1", tdc_rst_n); end
    tests_run++; if (busy !== 1'b0)       begin tests_failed++; $display("FAIL idle_busy: got %b want 0", busy); end
    tests_run++; if (conv_start !== 1'b0) begin tests_failed++; $display("FAIL idle_conv_start: got %b want 0", conv_start); end
  endtask

  // Leaves the DUT in HOLD for test_backpressure.
  task automatic test_single();
    run_one(2'b10, 2'b10, 2'b10, 2'b10);
    tests_run++; if (r_lat != LAT)         begin tests_failed++; $display("FAIL single_latency: got %0d want %0d", r_lat, LAT); end
    tests_run++; if (r_firstclr != 0)      begin tests_failed++; $display("FAIL single_clr_cycle: got %0d want 0", r_firstclr); end
    tests_run++; if (r_nclr != ROUNDS)     begin tests_failed++; $display("FAIL single_clr_len: got %0d want %0d", r_nclr, ROUNDS); end
    tests_run++; if (r_nstarts != ROUNDS)  begin tests_failed++; $display("FAIL single_nstarts: got %0d want %0d", r_nstarts, ROUNDS); end
    tests_run++; if (r_start[0] != 1)      begin tests_failed++; $display("FAIL single_start_cycle: got %0d want 1", r_start[0]); end
    tests_run++; if (res_data !== ACC_W'(2 * ROUNDS)) begin tests_failed++; $display("FAIL single_res_data: got %0d want %0d", res_data, 2 * ROUNDS); end
    tests_run++; if (busy !== 1'b1)        begin tests_failed++; $display("FAIL single_busy_hold: got %b want 1", busy); end
  endtask

  task automatic test_backpressure();
    int sc0;
    sc0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      req_valid = (i % 2 == 0);
      tick();
      tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_res_valid[%0d]: got %b want 1", i, res_valid); end
      tests_run++; if (res_data !== ACC_W'(2 * ROUNDS)) begin tests_failed++; $display("FAIL bp_res_data[%0d]: got %0d want %0d", i, res_data, 2 * ROUNDS); end
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
      tests_run++; if (busy !== 1'b1)      begin tests_failed++; $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); end
    end
    req_valid = 1'b0;
    tests_run++; if (start_cnt != sc0) begin tests_failed++; $display("FAIL bp_no_start: got %0d strobes want 0", start_cnt - sc0); end
    finish_hold();
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_res_valid: got %b want 0", res_valid); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_reset_mid_wait();
    int sc0;
    bit seen_valid;
    code_tab[0] = 2'b11; code_tab[1] = 2'b11; code_tab[2] = 2'b11; code_tab[3] = 2'b11;
    base = start_cnt;
    req_valid = 1'b1;
    tick();                     // accept edge
    req_valid = 1'b0;
    tick();                     // conv_start cycle
    tests_run++; if (conv_start !== 1'b1) begin tests_failed++; $display("FAIL mw_conv_start: got %b want 1", conv_start); end
    tick();
    tick();                     // two cycles after conv_start, inside WAIT
    sc0 = start_cnt;
    rst = 1'b1;
    tick();
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mw_busy_in_rst: got %b want 0", busy); end
    rst = 1'b0;
    tick();
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL mw_idle_req_ready: got %b want 1", req_ready); end
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL mw_idle_busy: got %b want 0", busy); end
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) seen_valid = 1'b1;
      tick();
    end
    tests_run++; if (seen_valid) begin tests_failed++; $display("FAIL mw_no_result: got res_valid=1 want 0"); end
    tests_run++; if (start_cnt != sc0) begin tests_failed++; $display("FAIL mw_no_strobe: got %0d strobes want 0", start_cnt - sc0); end
    run_one(2'b01, 2'b01, 2'b01, 2'b01);
    tests_run++; if (r_lat != LAT) begin tests_failed++; $display("FAIL mw_after_latency: got %0d want %0d", r_lat, LAT); end
    tests_run++; if (res_data !== ACC_W'(ROUNDS)) begin tests_failed++; $display("FAIL mw_after_res_data: got %0d want %0d", res_data, ROUNDS); end
    finish_hold();
  endtask

  task automatic test_acc();
    run_one(2'd3, 2'd1, 2'd2, 2'd0);
`ifdef TDC_CTRL_ACC_EN
    tests_run++; if (r_nstarts != 4) begin tests_failed++; $display("FAIL acc_nstarts: got %0d want 4", r_nstarts); end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (r_start[k] != 1 + 7 * k) begin tests_failed++; $display("FAIL acc_start_cycle[%0d]: got %0d want %0d", k, r_start[k], 1 + 7 * k); end
    end
    tests_run++; if (r_lat != 28) begin tests_failed++; $display("FAIL acc_latency: got %0d want 28", r_lat); end
    tests_run++; if (res_data !== 4'b0110) begin tests_failed++; $display("FAIL acc_res_data: got %0d want 6", res_data); end
`else
    tests_run++; if (r_nstarts != 1) begin tests_failed++; $display("FAIL acc_off_nstarts: got %0d want 1", r_nstarts); end
    tests_run++; if (r_lat != 7)     begin tests_failed++; $display("FAIL acc_off_latency: got %0d want 7", r_lat); end
    tests_run++; if (res_data !== 4'b0011) begin tests_failed++; $display("FAIL acc_off_res_data: got %0d want 3", res_data); end
`endif
    finish_hold();
  endtask

  task automatic test_back_to_back();
    int res_t [4];
    int n_res, starts_between;
    code_tab[0] = 2'b01; code_tab[1] = 2'b01; code_tab[2] = 2'b01; code_tab[3] = 2'b01;
    n_res = 0;
    starts_between = 0;
    res_ready = 1'b1;
    req_valid = 1'b1;
    for (int t = 0; t < 3 * PERIOD + 4; t++) begin
      tick();
      if (conv_start && n_res == 1) starts_between++;
      if (res_valid) begin
        tests_run++;
        if (res_data !== ACC_W'(ROUNDS)) begin tests_failed++; $display("FAIL b2b_res_data[%0d]: got %0d want %0d", n_res, res_data, ROUNDS); end
        if (n_res < 4) res_t[n_res] = t;
        n_res++;
      end
    end
    req_valid = 1'b0;
    tests_run++; if (n_res != 3) begin tests_failed++; $display("FAIL b2b_count: got %0d want 3", n_res); end
    if (n_res >= 3) begin
      tests_run++; if (res_t[0] != LAT) begin tests_failed++; $display("FAIL b2b_first: got %0d want %0d", res_t[0], LAT); end
      tests_run++; if (res_t[1] - res_t[0] != PERIOD) begin tests_failed++; $display("FAIL b2b_period0: got %0d want %0d", res_t[1] - res_t[0], PERIOD); end
      tests_run++; if (res_t[2] - res_t[1] != PERIOD) begin tests_failed++; $display("FAIL b2b_period1: got %0d want %0d", res_t[2] - res_t[1], PERIOD); end
    end
    tests_run++; if (starts_between != ROUNDS) begin tests_failed++; $display("FAIL b2b_starts_per_result: got %0d want %0d", starts_between, ROUNDS); end
    for (int i = 0; i < 2 * PERIOD; i++) tick();
    res_ready = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_reset_mid_wait();
    test_acc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
